// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the single unified memory port
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on conflict.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              stall_mem,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [2:0]        funct3,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_in,
    input  logic [31:0]       data_out
);

    localparam logic [2:0] FUNCT3_LW = 3'b010;

    logic [3:0] wait_cnt;
    logic       last_gnt;
    logic       gnt_if;
    logic       gnt_d;
    logic       at_limit;

    assign at_limit = (wait_cnt == 4'(MAX_WAIT));

    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Alternate on conflict; an over-waited fetch still wins outright.
            if (at_limit || last_gnt) begin
                gnt_if = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
`else
            if (at_limit) begin
                gnt_if = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
`endif
        end else if (if_req) begin
            gnt_if = 1'b1;
        end else if (d_req) begin
            gnt_d = 1'b1;
        end
    end

    assign stall_if  = if_req & ~gnt_if;
    assign stall_mem = d_req & ~gnt_d;

    // Strobes are gated by reset so nothing reaches memory during the reset cycle.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        addr     = '0;
        data_in  = 32'h0;
        if (gnt_if) begin
            MemRead = rst;
            funct3  = FUNCT3_LW;
            addr    = if_addr;
        end else if (gnt_d) begin
            MemRead  = rst & ~d_we;
            MemWrite = rst & d_we;
            funct3   = d_funct3;
            addr     = d_addr;
            data_in  = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            wait_cnt <= 4'd0;
            last_gnt <= 1'b0;
        end else begin
            if_valid <= gnt_if;
            d_valid  <= gnt_d;
            if (gnt_if) begin
                if_rdata <= data_out;
            end
            if (gnt_d && !d_we) begin
                d_rdata <= data_out;
            end
            if (gnt_if || !if_req) begin
                wait_cnt <= 4'd0;
            end else if (!at_limit) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (gnt_if) begin
                last_gnt <= 1'b0;
            end else if (gnt_d) begin
                last_gnt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a byte memory model
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        stall_if;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_mem;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [7:0]  mem [256];

    mem_port_arbiter #(.ADDR_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_mem(stall_mem),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        b0 = mem[addr];
        b1 = mem[addr + 8'd1];
        b2 = mem[addr + 8'd2];
        b3 = mem[addr + 8'd3];
        case (funct3)
            3'b000:  data_out = {{24{b0[7]}}, b0};
            3'b001:  data_out = {{16{b1[7]}}, b1, b0};
            3'b010:  data_out = {b3, b2, b1, b0};
            3'b100:  data_out = {24'h0, b0};
            3'b101:  data_out = {16'h0, b1, b0};
            default: data_out = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (MemWrite === 1'b1) begin
            mem[addr] <= data_in[7:0];
            if (funct3[1:0] != 2'b00) mem[addr + 8'd1] <= data_in[15:8];
            if (funct3[1:0] == 2'b10) begin
                mem[addr + 8'd2] <= data_in[23:16];
                mem[addr + 8'd3] <= data_in[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse consumes one expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                if (if_q.size() == 0) chk("if_valid unexpected", 32'd1, 32'd0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (d_valid === 1'b1) begin
                if (d_q.size() == 0) chk("d_valid unexpected", 32'd1, 32'd0);
                else chk("d_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    task automatic cyc(input string tag, input logic ir, input logic [7:0] ia,
                       input logic dr, input logic dwe, input logic [2:0] f3,
                       input logic [7:0] da, input logic [31:0] wd,
                       input logic gf, input logic gd,
                       input logic [31:0] ef, input logic [31:0] ed);
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_funct3 = f3; d_addr = da; d_wdata = wd;
        #1;
        chk({tag, " stall_if"}, {31'b0, stall_if}, {31'b0, ir & ~gf});
        chk({tag, " stall_mem"}, {31'b0, stall_mem}, {31'b0, dr & ~gd});
        if (gf) if_q.push_back(ef);
        if (gd) d_q.push_back(ed);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]} = 32'hFFB00093;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h11223344;
        mem[8'h30] = 8'h82;

        rst = 1'b0;
        if_req = 1'b0; if_addr = 8'h00;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
        #1;
        chk("reset MemWrite pre-edge", {31'b0, MemWrite}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset MemWrite", {31'b0, MemWrite}, 32'd0);
            chk("reset MemRead", {31'b0, MemRead}, 32'd0);
            chk("reset if_valid", {31'b0, if_valid}, 32'd0);
            chk("reset d_valid", {31'b0, d_valid}, 32'd0);
            chk("reset if_rdata", if_rdata, 32'h0);
            chk("reset d_rdata", d_rdata, 32'h0);
        end
        rst = 1'b1;

        cyc("load after reset", 0, 8'h00, 1, 0, 3'b010, 8'h10, 32'h0, 0, 1, 32'h0, 32'h11223344);
        cyc("fetch only", 1, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0, 1, 0, 32'hFFB00093, 32'h0);
        cyc("conflict LB", 1, 8'h00, 1, 0, 3'b000, 8'h30, 32'h0, 0, 1, 32'h0, 32'hFFFFFF82);
        cyc("fetch after conflict", 1, 8'h00, 0, 0, 3'b000, 8'h00, 32'h0, 1, 0, 32'hFFB00093, 32'h0);
        idle("idle 1");
        chk("idle MemRead", {31'b0, MemRead}, 32'd0);
        chk("idle MemWrite", {31'b0, MemWrite}, 32'd0);
        cyc("store SH", 0, 8'h00, 1, 1, 3'b001, 8'h21, 32'h0000ABCD, 0, 1, 32'h0, 32'hFFFFFF82);
        cyc("load LHU", 0, 8'h00, 1, 0, 3'b101, 8'h21, 32'h0, 0, 1, 32'h0, 32'h0000ABCD);
        idle("idle 2");

`ifndef MEM_ARB_ROUND_ROBIN_EN
        // Fixed priority: four refusals, then fetch forced through, twice over.
        for (int i = 0; i < 10; i++) begin
            logic gf;
            gf = (i == 4) || (i == 9);
            cyc($sformatf("starve %0d", i), 1, 8'h00, 1, 0, 3'b010, 8'h10, 32'h0,
                gf, !gf, 32'hFFB00093, 32'h11223344);
        end
`else
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic gf;
            gf = (i % 2) == 1;
            cyc($sformatf("rr %0d", i), 1, 8'h00, 1, 0, 3'b010, 8'h10, 32'h0,
                gf, !gf, 32'hFFB00093, 32'h11223344);
        end
`endif

        idle("drain 1");
        idle("drain 2");
        chk("if queue drained", if_q.size(), 32'd0);
        chk("d queue drained", d_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sits between the pipeline's fetch and memory stages and the single-ported, byte-addressable unified `Memory`. Each cycle it grants the one memory port to either the instruction-fetch requester or the load/store requester and drives `MemRead`/`MemWrite`/`funct3`/`addr`/`data_in` accordingly. It registers the returned read data per requester and raises per-stage stalls so the pipeline holds while it waits for the port. A bounded-wait counter prevents fetch starvation under back-to-back data traffic.

## Interface
- `ADDR_W`, 8, byte-address width; matches the memory's 256-byte array.
- `MAX_WAIT`, 4, number of consecutive refused fetch cycles after which fetch wins the next conflict (1..15).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request; always a word read (LW).
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_rdata`  out  32  registered instruction word.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` updated.
- `stall_if`  out  1  fetch requested but not granted this cycle.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_funct3`  in  3  RISC-V funct3 (SB/SH/SW, LB/LH/LW/LBU/LHU), passed through.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  32  store data.
- `d_rdata`  out  32  registered, already extended load result.
- `d_valid`  out  1  one-cycle pulse: load or store completed.
- `stall_mem`  out  1  data requested but not granted this cycle.
- `MemRead`, `MemWrite`  out  1 each  to memory.
- `funct3`  out  3  to memory.
- `addr`  out  ADDR_W  to memory.
- `data_in`  out  32  to memory.
- `data_out`  in  32  from memory (combinational read).

## Operation
- Grant is decided combinationally from `if_req`, `d_req`, and the registered state `wait_cnt` (4 bits) and `last_gnt` (1 bit: 0 = fetch, 1 = data).
- Only `if_req`: grant fetch. Memory port: `MemRead`=1, `MemWrite`=0, `funct3`=3'b010, `addr`=`if_addr`, `data_in`=0.
- Only `d_req`: grant data. Memory port: `MemRead`=~`d_we`, `MemWrite`=`d_we`, `funct3`=`d_funct3`, `addr`=`d_addr`, `data_in`=`d_wdata`.
- Both requests: grant data, unless `wait_cnt`==`MAX_WAIT`, in which case grant fetch.
- Neither request: all memory outputs are 0.
- On a fetch grant: at the posedge, `if_rdata`<=`data_out` and `if_valid`<=1.
- On a data grant: at the posedge, `d_valid`<=1; for a load, also `d_rdata`<=`data_out`. For a store, `d_rdata` holds its value.
- Rdata registers hold until the next grant to the same requester. Valid flags fall after one cycle unless the requester is granted again.
- `stall_if` = `if_req` & ~gnt_if; `stall_mem` = `d_req` & ~gnt_d. Both are combinational.
- `wait_cnt`:
  - increments (saturating at `MAX_WAIT`) each cycle `stall_if` is 1;
  - clears on a fetch grant or when `if_req`=0.
- `last_gnt` updates on every grant.
- Requester rule: hold req and all fields stable while stalled. Dropping req while stalled (flush) is legal and leaves no side effect.
- Reset (`rst`=0 at a posedge):
  - outputs/state cleared: `if_rdata`, `d_rdata`, `if_valid`, `d_valid`, `wait_cnt`, `last_gnt` all 0.
  - `MemWrite` and `MemRead` are forced to 0 while `rst`=0, so a store presented in the reset cycle is not written.

## Timing
- Latency is 1 cycle: a grant in cycle N gives a valid pulse and data in cycle N+1. A store commits at the posedge ending cycle N.
- Throughput is one access per cycle. Back-to-back grants to the same requester give `valid` high on consecutive cycles.
- Combinational paths:
  - req/addr -> memory port;
  - req -> `stall_*` (same cycle).
- No combinational path from `data_out` to any output.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: on a conflict, grant the requester opposite to `last_gnt`; `wait_cnt` forcing remains active as well.
  - Undefined: fixed data priority with `MAX_WAIT` anti-starvation only (as above).

## Test plan
- Reset: `rst`=0 with `d_req`=1, `d_we`=1, `d_addr`=8'h10, `d_wdata`=32'hDEADBEEF -> `MemWrite`=0; after release, a load of 8'h10 returns the preloaded value, all outputs were 0 during reset.
- Fetch only: `if_addr`=0 where mem holds 32'hFFB00093 -> next cycle `if_valid`=1, `if_rdata`=32'hFFB00093, `stall_if`=0.
- Conflict: `if_req` and `d_req` with LB at 8'h30 (byte 8'h82) -> `stall_if`=1, next cycle `d_valid`=1, `d_rdata`=32'hFFFFFF82; fetch is granted the following cycle.
- Starvation (MAX_WAIT=4, macro undefined): `d_req` held for 10 cycles with `if_req` held -> fetch is granted on the 5th cycle, then data resumes.
- Store then load: SH 32'h0000ABCD at 8'h21, then LHU 8'h21 -> `d_rdata`=32'h0000ABCD.
- `MEM_ARB_ROUND_ROBIN_EN` defined: continuous conflict -> grants alternate D,F,D,F starting with data after reset (`last_gnt`=0).
